// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: req/ack memory port shared by instruction fetch, loads and stores
interface ctrl_fsm_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle fetch/decode/execute controller driving the reg_alu datapath
module ctrl_fsm (
  input  logic        clk,
  input  logic        rst_n,
  ctrl_fsm_if.master  mem,
  input  logic [15:0] dSrc,
  input  logic [15:0] dDst,
  input  logic [4:0]  psrOut,
  output logic        write,
  output logic        IMM_MUX,
  output logic        SRAM_OUT,
  output logic        ALU_OUT,
  output logic        RA_BUF,
  output logic [3:0]  rSrc,
  output logic [3:0]  rDst,
  output logic [3:0]  aluOp,
  output logic [15:0] imm,
  output logic [15:0] pc,
  output logic [4:0]  psr,
  output logic        illegal
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, LINK} state_t;
  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d, pc_q, pc_d;
  logic [4:0]  psr_q, psr_d;
  logic [3:0]  op, ext, cond, code;
  logic [7:0]  imm8;
  logic        is_r, is_i, is_lui, is_alu, is_ld, is_st, is_jal, is_jc, is_bc, legal, taken;

  assign op     = ir_q[15:12];
  assign cond   = ir_q[11:8];
  assign ext    = ir_q[7:4];
  assign imm8   = ir_q[7:0];
  assign is_r   = op == 4'h0 && ext inside {4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD};
  assign is_i   = op inside {4'h5, 4'h9, 4'h1, 4'h2, 4'h3, 4'hB, 4'hD};
  assign is_lui = op == 4'hF;
  assign is_alu = is_r | is_i | is_lui;
  assign is_ld  = op == 4'h4 && ext == 4'h0;
  assign is_st  = op == 4'h4 && ext == 4'h4;
  assign is_jal = op == 4'h4 && ext == 4'h8;
  assign is_jc  = op == 4'h4 && ext == 4'hC;
  assign is_bc  = op == 4'hC;
  assign legal  = is_alu | is_ld | is_st | is_jal | is_jc | is_bc;
  assign code   = is_r ? ext : op;
  // psr is {N,Z,F,L,C}; only N, Z and C feed branch conditions
  assign taken  = (cond == 4'h0 &  psr_q[3]) | (cond == 4'h1 & ~psr_q[3]) |
                  (cond == 4'h2 &  psr_q[0]) | (cond == 4'h3 & ~psr_q[0]) |
                  (cond == 4'h6 &  psr_q[4]) | (cond == 4'h7 & ~psr_q[4]) | (cond == 4'hE);

  // decode fields come straight from the latched word, so they hold for the whole instruction
  assign rSrc    = ir_q[3:0];
  assign rDst    = ir_q[11:8];
  assign aluOp   = is_r ? ext : is_lui ? 4'hD : is_i ? op : 4'h0;
  assign IMM_MUX = is_i | is_lui;
  assign imm     = is_lui ? {imm8, 8'h00} : op inside {4'h1, 4'h2, 4'h3} ? {8'h00, imm8} : {{8{imm8[7]}}, imm8};
  assign pc      = pc_q;
  assign psr     = psr_q;
  // gated by rst_n so a request vanishes the instant reset is asserted
  assign mem.mem_req   = rst_n && (state_q == FETCH || state_q == MEM);
  assign mem.mem_wdata = dDst;

  // state, instruction, pc and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      ir_q    <= '0;
      pc_q    <= '0;
      psr_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      psr_q   <= psr_d;
    end
  end

  // next-state, register updates and per-state strobes
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    pc_d         = pc_q;
    psr_d        = psr_q;
    mem.mem_we   = 1'b0;
    mem.mem_addr = pc_q;
    write        = 1'b0;
    ALU_OUT      = 1'b0;
    SRAM_OUT     = 1'b0;
    RA_BUF       = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      FETCH: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + 16'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        illegal = ~legal;
        state_d = is_alu ? EXEC : (is_ld | is_st) ? MEM : is_jal ? LINK : FETCH;
        pc_d    = (is_jc & taken) ? dSrc : (is_bc & taken) ? pc_q + imm : pc_q;
      end
      EXEC: begin
        ALU_OUT = 1'b1;
        write   = code != 4'hB;
        psr_d   = code inside {4'h5, 4'h9, 4'hB} ? psrOut : psr_q;
        state_d = FETCH;
      end
      MEM: begin
        mem.mem_we   = is_st;
        mem.mem_addr = dSrc;
        state_d      = mem.mem_ack ? (is_ld ? WB : FETCH) : MEM;
      end
      WB: begin
        SRAM_OUT = 1'b1;
        write    = 1'b1;
        state_d  = FETCH;
      end
      LINK: begin
        RA_BUF  = 1'b1;
        write   = 1'b1;
        pc_d    = dSrc;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end
endmodule
